// File: rtl/tile_bank_loader.sv
// Tile bank loader: accepts a row stream for one operand over valid/ready and
// writes it into a ping/pong bank pair, one k-tile per bank. Publishes per-bank
// readiness flags and row counts for the tile scheduler, which hands banks back
// with release pulses.
module tile_bank_loader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 16,
  parameter int unsigned TK_W   = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      abort,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*DATA_W-1:0]   s_data,
  input  logic                      s_last,
  output logic                      wr_en,
  output logic                      wr_bank,
  output logic [TK_W-1:0]           wr_addr,
  output logic [LANES*DATA_W-1:0]   wr_data,
  input  logic                      rel_ping,
  input  logic                      rel_pong,
  output logic                      valid_ping,
  output logic                      valid_pong,
  output logic [TK_W:0]             rows_ping,
  output logic [TK_W:0]             rows_pong,
  output logic [15:0]               tiles_loaded,
  output logic [31:0]               stall_cycles,
  output logic                      err_overflow
);

  localparam int unsigned RowW = LANES * DATA_W;
  localparam logic [TK_W-1:0] AddrMax = {TK_W{1'b1}};

  typedef enum logic [0:0] {StFill, StCommit} state_e;

  state_e            state_q, state_d;
  logic              fill_bank_q, fill_bank_d;
  logic [TK_W-1:0]   fill_addr_q, fill_addr_d;
  // valid_q[0] = ping, valid_q[1] = pong
  logic [1:0]        valid_q, valid_d;
  logic [TK_W:0]     rows_ping_q, rows_ping_d;
  logic [TK_W:0]     rows_pong_q, rows_pong_d;
  logic [15:0]       tiles_q, tiles_d;
  logic [31:0]       stall_q, stall_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_bank_q, wr_bank_d;
  logic [TK_W-1:0]   wr_addr_q, wr_addr_d;
  logic [RowW-1:0]   wr_data_q, wr_data_d;

  logic              accept;
  logic              tile_end;

  // Ready depends only on registered state and abort, never on s_valid.
  // Held low while reset is asserted.
  assign s_ready  = rst_n && (state_q == StFill) && !valid_q[fill_bank_q] && !abort;
  assign accept   = s_valid && s_ready;
  assign tile_end = accept && (s_last || (fill_addr_q == AddrMax));

  // Next-state logic: row acceptance, commit, release, abort and counters.
  always_comb begin
    state_d     = state_q;
    fill_bank_d = fill_bank_q;
    fill_addr_d = fill_addr_q;
    rows_ping_d = rows_ping_q;
    rows_pong_d = rows_pong_q;
    tiles_d     = tiles_q;
    stall_d     = stall_q;
    err_d       = err_q;
    wr_en_d     = 1'b0;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    // Releases apply first so a commit in the same cycle overrides them.
    valid_d     = valid_q & ~{rel_pong, rel_ping};

    unique case (state_q)
      StFill: begin
        if (accept) begin
          wr_en_d     = 1'b1;
          wr_bank_d   = fill_bank_q;
          wr_addr_d   = fill_addr_q;
          wr_data_d   = s_data;
          fill_addr_d = fill_addr_q + 1'b1;
          if (tile_end) begin
            state_d     = StCommit;
            fill_addr_d = '0;
            if (fill_bank_q) begin
              rows_pong_d = {1'b0, fill_addr_q} + 1'b1;
            end else begin
              rows_ping_d = {1'b0, fill_addr_q} + 1'b1;
            end
            // A full bank without s_last is a forced split of an oversized tile.
            if (!s_last) begin
              err_d = 1'b1;
            end
          end
        end
      end
      StCommit: begin
        // Flag rises the cycle after the last RAM write, never ahead of data.
        valid_d[fill_bank_q] = 1'b1;
        tiles_d              = tiles_q + 16'd1;
        fill_bank_d          = ~fill_bank_q;
        state_d              = StFill;
      end
      default: state_d = StFill;
    endcase

    if (s_valid && !s_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end

    // Abort drops the partial tile and any tile mid-commit; statistics survive.
    if (abort) begin
      state_d     = StFill;
      valid_d     = 2'b00;
      fill_addr_d = '0;
      fill_bank_d = 1'b0;
      wr_en_d     = 1'b0;
      tiles_d     = tiles_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      fill_bank_q <= 1'b0;
      fill_addr_q <= '0;
      valid_q     <= 2'b00;
      rows_ping_q <= '0;
      rows_pong_q <= '0;
      tiles_q     <= '0;
      stall_q     <= '0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      fill_bank_q <= fill_bank_d;
      fill_addr_q <= fill_addr_d;
      valid_q     <= valid_d;
      rows_ping_q <= rows_ping_d;
      rows_pong_q <= rows_pong_d;
      tiles_q     <= tiles_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_bank      = wr_bank_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign valid_ping   = valid_q[0];
  assign valid_pong   = valid_q[1];
  assign rows_ping    = rows_ping_q;
  assign rows_pong    = rows_pong_q;
  assign tiles_loaded = tiles_q;
  assign stall_cycles = stall_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_tile_bank_loader.sv
// Bench for tile_bank_loader: directed tiles on a default instance plus a
// TK_W=2 instance for overflow. Expected RAM writes are queued at accept time
// and checked by per-instance monitors whenever wr_en is seen.
module tb_tile_bank_loader;

  localparam int RW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance 0: TK_W = 6
  logic          abort0, s_valid0, s_ready0, s_last0, wr_en0, wr_bank0;
  logic [RW-1:0] s_data0, wr_data0;
  logic [5:0]    wr_addr0;
  logic          rel_ping0, rel_pong0, valid_ping0, valid_pong0, err0;
  logic [6:0]    rows_ping0, rows_pong0;
  logic [15:0]   tiles0;
  logic [31:0]   stall0;

  // Instance 1: TK_W = 2
  logic          abort1, s_valid1, s_ready1, s_last1, wr_en1, wr_bank1;
  logic [RW-1:0] s_data1, wr_data1;
  logic [1:0]    wr_addr1;
  logic          rel_ping1, rel_pong1, valid_ping1, valid_pong1, err1;
  logic [2:0]    rows_ping1, rows_pong1;
  logic [15:0]   tiles1;
  logic [31:0]   stall1;

  tile_bank_loader #(.DATA_W(8), .LANES(16), .TK_W(6)) dut0 (
    .clk(clk), .rst_n(rst_n), .abort(abort0), .s_valid(s_valid0), .s_ready(s_ready0),
    .s_data(s_data0), .s_last(s_last0), .wr_en(wr_en0), .wr_bank(wr_bank0),
    .wr_addr(wr_addr0), .wr_data(wr_data0), .rel_ping(rel_ping0), .rel_pong(rel_pong0),
    .valid_ping(valid_ping0), .valid_pong(valid_pong0), .rows_ping(rows_ping0),
    .rows_pong(rows_pong0), .tiles_loaded(tiles0), .stall_cycles(stall0),
    .err_overflow(err0)
  );

  tile_bank_loader #(.DATA_W(8), .LANES(16), .TK_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .abort(abort1), .s_valid(s_valid1), .s_ready(s_ready1),
    .s_data(s_data1), .s_last(s_last1), .wr_en(wr_en1), .wr_bank(wr_bank1),
    .wr_addr(wr_addr1), .wr_data(wr_data1), .rel_ping(rel_ping1), .rel_pong(rel_pong1),
    .valid_ping(valid_ping1), .valid_pong(valid_pong1), .rows_ping(rows_ping1),
    .rows_pong(rows_pong1), .tiles_loaded(tiles1), .stall_cycles(stall1),
    .err_overflow(err1)
  );

  typedef logic [134:0] exp_t;  // {bank, addr[5:0], data[127:0]}
  exp_t q0[$];
  exp_t q1[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input int n);
    logic [15:0] h;
    h = n[15:0] ^ 16'h5A3C;
    return {8{h}};
  endfunction

  // Monitor for instance 0 RAM writes.
  always @(negedge clk) begin : mon0
    exp_t a, e;
    if (rst_n && wr_en0) begin
      a = {wr_bank0, wr_addr0, wr_data0};
      n_cmp++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL wr0_unexpected: got %h expected none", a);
      end else begin
        e = q0.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL wr0_beat: got %h expected %h", a, e);
        end
      end
    end
  end

  // Monitor for instance 1 RAM writes.
  always @(negedge clk) begin : mon1
    exp_t a, e;
    if (rst_n && wr_en1) begin
      a = {wr_bank1, 4'b0000, wr_addr1, wr_data1};
      n_cmp++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL wr1_unexpected: got %h expected none", a);
      end else begin
        e = q1.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL wr1_beat: got %h expected %h", a, e);
        end
      end
    end
  end

  // Offer one row and wait (bounded) for it to be accepted; returns at accept edge + 1.
  task automatic push_row(input int which, input logic [RW-1:0] d, input logic l,
                          input logic eb, input logic [5:0] ea);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    if (which == 0) begin s_valid0 = 1'b1; s_data0 = d; s_last0 = l; end
    else            begin s_valid1 = 1'b1; s_data1 = d; s_last1 = l; end
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = (which == 0) ? s_ready0 : s_ready1;
      @(posedge clk);
      #1;
      n++;
    end
    if (which == 0) begin s_valid0 = 1'b0; s_last0 = 1'b0; end
    else            begin s_valid1 = 1'b0; s_last1 = 1'b0; end
    if (acc) begin
      if (which == 0) q0.push_back({eb, ea, d});
      else            q1.push_back({eb, ea, d});
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no s_ready expected accept");
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [31:0] st;
    rst_n = 1'b0;
    {abort0, s_valid0, s_last0, rel_ping0, rel_pong0} = '0;
    {abort1, s_valid1, s_last1, rel_ping1, rel_pong1} = '0;
    s_data0 = '0;
    s_data1 = '0;
    s_valid0 = 1'b1;  // ready must stay low during reset even with valid offered
    repeat (2) @(negedge clk);
    check("rst_ready", s_ready0, 0);
    check("rst_wr_en", wr_en0, 0);
    check("rst_valid", {valid_ping0, valid_pong0}, 0);
    check("rst_tiles", tiles0, 0);
    check("rst_err", err0, 0);
    s_valid0 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_stall", stall0, 0);

    // Basic fill: 4 rows into ping.
    for (int i = 0; i < 4; i++) push_row(0, mk(i), i == 3, 1'b0, 6'(i));
    check("t1_commit_ready", s_ready0, 0);
    check("t1_flag_early", valid_ping0, 0);
    tick();
    check("t1_valid_ping", valid_ping0, 1);
    check("t1_rows_ping", rows_ping0, 4);
    check("t1_tiles", tiles0, 1);

    // Second tile goes to pong.
    for (int i = 0; i < 4; i++) push_row(0, mk(10 + i), i == 3, 1'b1, 6'(i));
    tick();
    check("t2_valid_pong", valid_pong0, 1);
    check("t2_rows_pong", rows_pong0, 4);
    check("t2_tiles", tiles0, 2);

    // Both banks full: back-pressure counts stalls until ping is released.
    s_valid0 = 1'b1;
    s_data0 = mk(20);
    s_last0 = 1'b0;
    #1;
    check("bp_ready_low", s_ready0, 0);
    st = stall0;
    repeat (3) tick();
    check("bp_stall3", stall0, st + 32'd3);
    rel_ping0 = 1'b1;
    tick();
    rel_ping0 = 1'b0;
    #1;
    check("bp_rel_valid", valid_ping0, 0);
    check("bp_rel_ready", s_ready0, 1);
    check("bp_stall4", stall0, st + 32'd4);
    for (int i = 0; i < 4; i++) push_row(0, mk(20 + i), i == 3, 1'b0, 6'(i));
    tick();
    check("t3_valid_ping", valid_ping0, 1);
    check("t3_tiles", tiles0, 3);
    check("t3_full_ready", s_ready0, 0);

    // Tile 4 into pong after releasing it.
    rel_pong0 = 1'b1;
    tick();
    rel_pong0 = 1'b0;
    for (int i = 0; i < 4; i++) push_row(0, mk(30 + i), i == 3, 1'b1, 6'(i));
    tick();
    check("t4_tiles", tiles0, 4);

    // Tile 5 (3 rows) into ping; release pong during the ping COMMIT cycle.
    rel_ping0 = 1'b1;
    tick();
    rel_ping0 = 1'b0;
    for (int i = 0; i < 3; i++) push_row(0, mk(40 + i), i == 2, 1'b0, 6'(i));
    rel_pong0 = 1'b1;
    tick();
    rel_pong0 = 1'b0;
    check("sim_valid_ping", valid_ping0, 1);
    check("sim_valid_pong", valid_pong0, 0);
    check("sim_rows_ping", rows_ping0, 3);
    check("sim_tiles", tiles0, 5);

    // Release of a bank that is not valid changes nothing.
    rel_pong0 = 1'b1;
    tick();
    rel_pong0 = 1'b0;
    check("nop_rel_pong", valid_pong0, 0);
    check("nop_rel_ping", valid_ping0, 1);

    // Abort after 2 rows of a pong tile.
    for (int i = 0; i < 2; i++) push_row(0, mk(50 + i), 1'b0, 1'b1, 6'(i));
    st = stall0;
    abort0 = 1'b1;
    #1;
    check("ab_ready", s_ready0, 0);
    tick();
    abort0 = 1'b0;
    check("ab_valid", {valid_ping0, valid_pong0}, 0);
    check("ab_tiles", tiles0, 5);
    check("ab_stall", stall0, st);
    check("ab_err", err0, 0);
    for (int i = 0; i < 4; i++) push_row(0, mk(60 + i), i == 3, 1'b0, 6'(i));
    tick();
    check("ab_next_valid", valid_ping0, 1);
    check("ab_next_rows", rows_ping0, 4);
    check("ab_next_tiles", tiles0, 6);

    // Overflow on the 4-deep instance: 6 rows, no s_last.
    for (int i = 0; i < 6; i++) begin
      push_row(1, mk(70 + i), 1'b0, (i >= 4) ? 1'b1 : 1'b0, 6'(i % 4));
    end
    check("ov_valid_ping", valid_ping1, 1);
    check("ov_rows_ping", rows_ping1, 4);
    check("ov_err", err1, 1);
    check("ov_tiles", tiles1, 1);
    check("ov_stall", stall1, 1);
    check("ov_valid_pong", valid_pong1, 0);
    check("ov_err_other", err0, 0);

    // Reset mid-tile clears everything immediately.
    for (int i = 0; i < 2; i++) push_row(0, mk(80 + i), 1'b0, 1'b1, 6'(i));
    tick();
    rst_n = 1'b0;
    #1;
    check("mr_valid", {valid_ping0, valid_pong0}, 0);
    check("mr_tiles", tiles0, 0);
    check("mr_wr_en", wr_en0, 0);
    check("mr_ready", s_ready0, 0);
    tick();
    rst_n = 1'b1;

    repeat (3) tick();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_bank_loader.md
Name: tile_bank_loader

Overview:
- Upstream producer for the tile scheduler. Accepts a row stream of one operand (A or B) over valid/ready and writes it into a ping/pong bank pair, one k-tile per bank.
- Drives the `valid_ping` / `valid_pong` bank-readiness flags that the scheduler gates `rd_en` on.
- The scheduler returns each bank with a release pulse once it has consumed it.
- Two instances are used per accelerator: one for A, one for B.

Parameters:
- DATA_W, 8, bits per lane element
- LANES, 16, elements per row (row width = LANES*DATA_W)
- TK_W, 6, bank address width; bank depth = 2**TK_W rows

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- abort  in  1  synchronous flush; same meaning as the scheduler's abort
- s_valid  in  1  input row valid
- s_ready  out  1  input row ready
- s_data  in  LANES*DATA_W  row payload
- s_last  in  1  last row of the current k-tile
- wr_en  out  1  bank RAM write enable (registered)
- wr_bank  out  1  bank RAM bank select: 0 = ping, 1 = pong (registered)
- wr_addr  out  TK_W  bank RAM row address (registered)
- wr_data  out  LANES*DATA_W  bank RAM write data (registered)
- rel_ping  in  1  consumer finished with ping; one-cycle pulse
- rel_pong  in  1  consumer finished with pong; one-cycle pulse
- valid_ping  out  1  ping bank holds a complete k-tile
- valid_pong  out  1  pong bank holds a complete k-tile
- rows_ping  out  TK_W+1  row count of the tile in ping (Tk_eff)
- rows_pong  out  TK_W+1  row count of the tile in pong
- tiles_loaded  out  16  completed k-tiles; wraps modulo 2**16
- stall_cycles  out  32  count of cycles with s_valid && !s_ready; saturates at all-ones
- err_overflow  out  1  sticky flag; a tile exceeded bank depth

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs and state go to 0.
  - fill_bank = 0 (ping), fill_addr = 0, FSM in FILL, s_ready = 0 during reset.
- State
  - fill_bank: 1-bit pointer to the bank being written.
  - fill_addr: TK_W-bit pointer to the next row.
  - FSM with states FILL and COMMIT.
- s_ready = (state == FILL) && !valid[fill_bank] && !abort. This is combinational from registers and abort only; it never depends on s_valid.
- Accept rule: a row is accepted on a rising edge with s_valid && s_ready.
- Per accepted row:
  - On the next cycle, wr_en = 1, wr_bank = fill_bank, wr_addr = fill_addr, wr_data = s_data.
  - fill_addr increments.
- Tile end:
  - The tile ends when an accepted row has s_last = 1, or when it is accepted with fill_addr == 2**TK_W - 1 (implicit end; also sets err_overflow).
  - FSM -> COMMIT, fill_addr -> 0, and rows_<bank> latches fill_addr + 1.
- COMMIT (one cycle; lines up with the last wr_en):
  - s_ready = 0.
  - valid[fill_bank] <= 1 and tiles_loaded++.
  - fill_bank toggles; FSM -> FILL.
  - Net effect: a valid flag rises 2 cycles after the edge that accepted the last row, i.e. the cycle after the RAM write. A flag never precedes its data.
- Back-pressure:
  - In FILL with valid[fill_bank] = 1, s_ready stays 0 until that bank is released.
  - Each such cycle with s_valid high increments stall_cycles.
- Release:
  - rel_ping clears valid_ping on the next edge; rel_pong likewise for valid_pong.
  - A release of a bank that is not valid is ignored.
  - A release and a COMMIT to the other bank in the same cycle both take effect.
  - Releasing the bank being committed cannot happen, because that bank is not yet valid; if it does occur, COMMIT wins.
  - s_ready may rise the cycle after the release edge. There is no combinational release-to-ready path.
- Steady state: with both banks free and continuous input, a Tk-row tile costs Tk + 1 cycles (Tk accept cycles plus the COMMIT bubble).
- Abort:
  - Clears valid_ping, valid_pong, fill_addr, fill_bank and wr_en, and returns the FSM to FILL.
  - Discards the partial tile.
  - Preserves tiles_loaded, stall_cycles and err_overflow.
- rows_* hold their value until the next commit into the same bank.
- Reset asserted mid-tile: everything clears immediately; no partial valid flag is ever left set.

Test Plan:
- Basic fill: TK_W=6, stream 4 rows with s_last on row 4 → wr_addr 0..3 on bank 0; valid_ping = 1 two cycles after the last accept; rows_ping = 4; tiles_loaded = 1; fill_bank = 1.
- Ping-pong with back-pressure: load tiles of 4, 4 and 4 rows with no release → after two tiles, s_ready = 0 and stall_cycles increments each cycle. Pulse rel_ping → s_ready = 1 the next cycle, and the third tile writes bank 0.
- Overflow: TK_W=2, stream 6 rows with no s_last → rows 0..3 commit to ping with rows_ping = 4 and err_overflow = 1; rows 4..5 go to pong at addresses 0..1.
- Simultaneous events: release pong in the same cycle as the COMMIT of ping → valid_ping = 1 and valid_pong = 0 afterwards. rel_ping while valid_ping = 0 → no change.
- Abort mid-tile: after 2 of 4 rows, assert abort for 1 cycle → valid flags = 0, fill_addr = 0, fill_bank = 0; the next tile restarts at bank 0, address 0; tiles_loaded is unchanged.
- Scheduler pairing: A and B instances feed the scheduler with M=N=4, K=8, Tm=Tn=2, Tk=4 and random input gaps of 0–5 cycles → the scheduler never asserts rd_en on an invalid bank, and all 4 tiles complete.
